clap_pattern_ctrl: RTL and testbench

CLAP_PATTERN_CTRL -- requirements
Module: clap_pattern_ctrl

---
 rtl/clap_pattern_ctrl.sv | 167 ++++++++++++++++
 tb/tb_clap_pattern_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/clap_pattern_ctrl.sv
// Clap pattern controller: counts rising edges of a clap-detector level,
// enforces a lockout after each accepted clap and a maximum gap before the
// next one, and reports a complete pattern or a gap timeout as one-cycle
// pulses. All outputs come straight from registers.
module clap_pattern_ctrl #(
    parameter int REQ_CLAPS   = 2,
    parameter int REFRACT_CYC = 2500000,
    parameter int GAP_MAX_CYC = 25000000,
    parameter int TW          = 26
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clap_detected,
    input  logic       arm,
    output logic       pattern_ok,
    output logic       pattern_fail,
    output logic       busy,
    output logic [3:0] clap_count,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REFRACT = 2'd1,
        S_WAIT    = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    // Terminal timer values; the timer restarts at 0 on every state entry
    // and is only ever compared for equality, so it can never wrap.
    localparam logic [TW-1:0] REFRACT_LAST = TW'(REFRACT_CYC - 1);
    localparam logic [TW-1:0] GAP_LAST     = TW'(GAP_MAX_CYC - 1);
    localparam logic [3:0]    REQ_COUNT    = 4'(REQ_CLAPS);
    localparam logic [TW-1:0] TIMER_ONE    = TW'(1);

    state_t        state_q;
    state_t        state_d;
    logic [TW-1:0] timer_q;
    logic [TW-1:0] timer_d;
    logic [3:0]    count_q;
    logic [3:0]    count_d;
    logic [3:0]    count_inc;
    logic          ok_q;
    logic          ok_d;
    logic          fail_q;
    logic          fail_d;
    logic          busy_q;
    logic          busy_d;
    logic          clap_prev;
    logic          clap_edge;

    // A held clap level produces exactly one edge; clap_prev resets high so
    // a level already present when reset releases is not taken as a clap.
    assign clap_edge = clap_detected & ~clap_prev;
    assign count_inc = count_q + 4'd1;

    // Next-state, timer, count and pulse decisions.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        count_d = count_q;
        ok_d    = 1'b0;
        fail_d  = 1'b0;

        if (!arm) begin
            // Disarming aborts the attempt silently and outranks any edge
            // or timer expiry in the same cycle.
            state_d = S_IDLE;
            timer_d = '0;
            count_d = 4'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    timer_d = '0;
                    count_d = 4'd0;
                    if (clap_edge) begin
                        count_d = 4'd1;
                        if (REQ_COUNT == 4'd1) begin
                            state_d = S_DONE;
                            ok_d    = 1'b1;
                        end else begin
                            state_d = S_REFRACT;
                        end
                    end
                end

                S_REFRACT: begin
                    // Edges are ignored while locked out.
                    if (timer_q == REFRACT_LAST) begin
                        state_d = S_WAIT;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + TIMER_ONE;
                    end
                end

                S_WAIT: begin
                    // An edge on the final gap cycle still counts.
                    if (clap_edge) begin
                        count_d = count_inc;
                        timer_d = '0;
                        if (count_inc == REQ_COUNT) begin
                            state_d = S_DONE;
                            ok_d    = 1'b1;
                        end else begin
                            state_d = S_REFRACT;
                        end
                    end else if (timer_q == GAP_LAST) begin
                        state_d = S_IDLE;
                        timer_d = '0;
                        count_d = 4'd0;
                        fail_d  = 1'b1;
                    end else begin
                        timer_d = timer_q + TIMER_ONE;
                    end
                end

                S_DONE: begin
                    // Post-pattern lockout; count stays at the full pattern.
                    if (timer_q == REFRACT_LAST) begin
                        state_d = S_IDLE;
                        timer_d = '0;
                        count_d = 4'd0;
                    end else begin
                        timer_d = timer_q + TIMER_ONE;
                    end
                end

                default: begin
                    state_d = S_IDLE;
                    timer_d = '0;
                    count_d = 4'd0;
                end
            endcase
        end

        busy_d = (state_d != S_IDLE);
    end

    // State, timer and registered outputs; reset discards any attempt.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            timer_q   <= '0;
            count_q   <= 4'd0;
            ok_q      <= 1'b0;
            fail_q    <= 1'b0;
            busy_q    <= 1'b0;
            clap_prev <= 1'b1;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            count_q   <= count_d;
            ok_q      <= ok_d;
            fail_q    <= fail_d;
            busy_q    <= busy_d;
            clap_prev <= clap_detected;
        end
    end

    assign pattern_ok   = ok_q;
    assign pattern_fail = fail_q;
    assign busy         = busy_q;
    assign clap_count   = count_q;
    assign state        = state_q;

endmodule

// File: tb/tb_clap_pattern_ctrl.sv
// Bench for clap_pattern_ctrl: two instances (two-clap and one-clap
// patterns) driven by the same inputs, compared every cycle against an
// elapsed-time reference model, plus scripted scenarios with literal values.
module tb_clap_pattern_ctrl;

    localparam int R = 4;
    localparam int G = 10;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic clap = 1'b0;
    logic arm = 1'b1;

    logic       ok_o   [2];
    logic       fail_o [2];
    logic       busy_o [2];
    logic [3:0] cnt_o  [2];
    logic [1:0] st_o   [2];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    clap_pattern_ctrl #(.REQ_CLAPS(2), .REFRACT_CYC(R), .GAP_MAX_CYC(G), .TW(8)) dut0 (
        .clk(clk), .reset(reset), .clap_detected(clap), .arm(arm),
        .pattern_ok(ok_o[0]), .pattern_fail(fail_o[0]), .busy(busy_o[0]),
        .clap_count(cnt_o[0]), .state(st_o[0]));

    clap_pattern_ctrl #(.REQ_CLAPS(1), .REFRACT_CYC(R), .GAP_MAX_CYC(G), .TW(8)) dut1 (
        .clk(clk), .reset(reset), .clap_detected(clap), .arm(arm),
        .pattern_ok(ok_o[1]), .pattern_fail(fail_o[1]), .busy(busy_o[1]),
        .clap_count(cnt_o[1]), .state(st_o[1]));

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: mode 0 idle, 1 attempt, 2 pattern done. Phases are
    // derived from the cycle at which the current attempt step began.
    int  cyc = 0;
    bit  started = 0;
    bit  m_prev = 1;
    int  req    [2] = '{2, 1};
    int  m_mode [2] = '{0, 0};
    int  m_cnt  [2] = '{0, 0};
    int  m_t0   [2] = '{0, 0};
    int  e_ok   [2] = '{0, 0};
    int  e_fail [2] = '{0, 0};
    int  e_st   [2] = '{0, 0};

    always @(posedge clk) begin
        bit e;
        int el;
        e = clap && !m_prev;
        for (int i = 0; i < 2; i++) begin
            e_ok[i] = 0;
            e_fail[i] = 0;
            if (reset || !arm) begin
                m_mode[i] = 0;
                m_cnt[i] = 0;
            end else if (m_mode[i] == 0) begin
                if (e) begin
                    m_cnt[i] = 1;
                    m_t0[i] = cyc + 1;
                    if (req[i] == 1) begin
                        m_mode[i] = 2;
                        e_ok[i] = 1;
                    end else begin
                        m_mode[i] = 1;
                    end
                end
            end else if (m_mode[i] == 1) begin
                el = cyc - m_t0[i];
                if (el >= R) begin
                    if (e) begin
                        m_cnt[i] = m_cnt[i] + 1;
                        m_t0[i] = cyc + 1;
                        if (m_cnt[i] == req[i]) begin
                            m_mode[i] = 2;
                            e_ok[i] = 1;
                        end
                    end else if (el - R == G - 1) begin
                        m_mode[i] = 0;
                        m_cnt[i] = 0;
                        e_fail[i] = 1;
                    end
                end
            end else begin
                if (cyc - m_t0[i] == R - 1) begin
                    m_mode[i] = 0;
                    m_cnt[i] = 0;
                end
            end
            case (m_mode[i])
                0: e_st[i] = 0;
                1: e_st[i] = ((cyc + 1 - m_t0[i]) < R) ? 1 : 2;
                default: e_st[i] = 3;
            endcase
        end
        m_prev = reset ? 1'b1 : clap;
        if (reset) started = 1;
        cyc++;
    end

    // Per-cycle comparison of both instances against the model.
    always @(posedge clk) begin
        #1;
        if (started) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("dut%0d.state", i), int'(st_o[i]), e_st[i]);
                chk($sformatf("dut%0d.clap_count", i), int'(cnt_o[i]), m_cnt[i]);
                chk($sformatf("dut%0d.pattern_ok", i), int'(ok_o[i]), e_ok[i]);
                chk($sformatf("dut%0d.pattern_fail", i), int'(fail_o[i]), e_fail[i]);
                chk($sformatf("dut%0d.busy", i), int'(busy_o[i]), (e_st[i] != 0) ? 1 : 0);
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic setup();
        reset = 1'b1;
        clap = 1'b0;
        arm = 1'b1;
        next_cycle();
        next_cycle();
        reset = 1'b0;
        next_cycle();
        next_cycle();
    endtask

    initial begin
        setup();
        chk("reset.state", int'(st_o[0]), 0);
        chk("reset.count", int'(cnt_o[0]), 0);
        chk("reset.busy", int'(busy_o[0]), 0);

        // Happy path: edges at cycles 0 and 7.
        for (int k = 0; k <= 13; k++) begin
            if (k > 0) next_cycle();
            if (k == 1) chk("happy.c1_refract", int'(st_o[0]), 1);
            if (k == 4) chk("happy.c4_refract", int'(st_o[0]), 1);
            if (k == 5) chk("happy.c5_wait", int'(st_o[0]), 2);
            if (k == 7) chk("happy.c7_ok", int'(ok_o[0]), 0);
            if (k == 8) chk("happy.c8_ok", int'(ok_o[0]), 1);
            if (k == 8) chk("happy.c8_count", int'(cnt_o[0]), 2);
            if (k == 9) chk("happy.c9_ok", int'(ok_o[0]), 0);
            if (k == 11) chk("happy.c11_done", int'(st_o[0]), 3);
            if (k == 12) chk("happy.c12_idle", int'(st_o[0]), 0);
            clap = (k == 0 || k == 7);
        end

        // Gap timeout after a single clap.
        setup();
        for (int k = 0; k <= 16; k++) begin
            if (k > 0) next_cycle();
            if (k == 5) chk("gap.c5_wait", int'(st_o[0]), 2);
            if (k == 14) chk("gap.c14_fail", int'(fail_o[0]), 0);
            if (k == 15) chk("gap.c15_fail", int'(fail_o[0]), 1);
            if (k == 15) chk("gap.c15_count", int'(cnt_o[0]), 0);
            if (k == 15) chk("gap.c15_idle", int'(st_o[0]), 0);
            if (k == 16) chk("gap.c16_fail", int'(fail_o[0]), 0);
            clap = (k == 0);
        end

        // Level held high for cycles 0-20.
        setup();
        for (int k = 0; k <= 21; k++) begin
            if (k > 0) next_cycle();
            if (k == 10) chk("hold.c10_count", int'(cnt_o[0]), 1);
            if (k == 15) chk("hold.c15_fail", int'(fail_o[0]), 1);
            clap = (k <= 20);
        end

        // Second edge on the last gap cycle (timer 9 at cycle 14).
        setup();
        for (int k = 0; k <= 16; k++) begin
            if (k > 0) next_cycle();
            if (k == 15) chk("edge_wins.ok", int'(ok_o[0]), 1);
            if (k == 15) chk("edge_wins.fail", int'(fail_o[0]), 0);
            clap = (k == 0 || k == 14);
        end

        // Arm dropped at cycle 6.
        setup();
        for (int k = 0; k <= 8; k++) begin
            if (k > 0) next_cycle();
            if (k == 7) chk("abort.state", int'(st_o[0]), 0);
            if (k == 7) chk("abort.count", int'(cnt_o[0]), 0);
            if (k == 7) chk("abort.pulses", int'(ok_o[0]) + int'(fail_o[0]), 0);
            clap = (k == 0);
            arm = (k != 6);
        end

        // Clap level held through and after reset.
        reset = 1'b1;
        clap = 1'b1;
        arm = 1'b1;
        next_cycle();
        next_cycle();
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            next_cycle();
            chk("rst_level.count", int'(cnt_o[0]), 0);
            chk("rst_level.state", int'(st_o[0]), 0);
        end

        // Reset in WAIT with one clap counted.
        setup();
        for (int k = 0; k <= 8; k++) begin
            if (k > 0) next_cycle();
            if (k == 6) chk("rst_wait.pre_count", int'(cnt_o[0]), 1);
            if (k == 7) chk("rst_wait.state", int'(st_o[0]), 0);
            if (k == 7) chk("rst_wait.outs", int'(cnt_o[0]) + int'(ok_o[0]) + int'(fail_o[0]) + int'(busy_o[0]), 0);
            clap = (k == 0);
            reset = (k == 6);
        end

        // Randomized traffic, dense then sparse claps.
        for (int k = 0; k < 4000; k++) begin
            next_cycle();
            reset = ($urandom_range(0, 299) == 0);
            arm = ($urandom_range(0, 149) != 0);
            if ($urandom_range(0, (k < 2000) ? 5 : 14) == 0) clap = ~clap;
        end

        next_cycle();
        next_cycle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
